load_store_unit: RTL
====================

# load_store_unit

Data-memory stage downstream of the single-cycle datapath: takes the ALU address (ALUResult) and store data (WriteData), runs a registered request/ready transaction on the data bus, and returns aligned, sign- or zero-extended ReadData. While a transaction is in flight it asserts Stall so the core holds PC and register writeback. It handles lb/lh/lw/lbu/lhu/sb/sh/sw byte lanes and has a bus timeout.

## Interface
- TIMEOUT, 255: maximum BUS-state cycles without BusReady before abort; 1..1023.
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- MemRead  in  1  load in progress (from controller).
- MemWrite  in  1  store in progress.
- Funct3  in  3  Instr[14:12]; size/sign.
- ALUResult  in  32  byte address.
- WriteData  in  32  store data, low-aligned.
- ReadData  out  32  extended load data.
- Stall  out  1  hold PC/regfile this cycle.
- Fault  out  1  one-cycle pulse on timeout or trapped misalignment.
- BusReq  out  1  request valid.
- BusWe  out  1  1 = write.
- BusAddr  out  32  word address, [1:0] = 0.
- BusWData  out  32  lane-shifted store data.
- BusBe  out  4  byte enables.
- BusReady  in  1  slave accepts/completes this cycle.
- BusRData  in  32  read word, valid with BusReady.

## Operation
- States IDLE, BUS, DONE. Reset: IDLE; ReadData=0, Fault=0, BusReq=0, BusWe=0, BusAddr=0, BusWData=0, BusBe=0, timeout counter=0.
- IDLE: if MemRead|MemWrite, latch address, Funct3, lanes, data into bus registers; go BUS. MemWrite wins if both asserted (BusWe=1).
- BUS: BusReq=1, bus outputs stable. BusReady → capture BusRData (reads), go DONE. Counter reaching TIMEOUT → drop BusReq, ReadData=0, Fault pulse, go DONE.
- DONE: Stall=0 for exactly one cycle; core retires instruction; unconditional → IDLE. No re-issue despite MemRead/MemWrite still high.
- Stall = (IDLE & (MemRead|MemWrite) & ~trapped) | BUS. Combinational.
- Lanes: off=ALUResult[1:0]. Byte: BusBe=0001<<off, data replicated ×4. Half: BusBe=0011<<(off[1]*2), data replicated ×2. Word: 1111.
- Load extract: select lane by off, extend: 000 lb sign, 001 lh sign, 010 lw, 100 lbu zero, 101 lhu zero.
- Funct3 011/110/111: treated as word.

## Timing
- Min memory-instruction latency 3 cycles (IDLE detect, BUS with BusReady, DONE retire); each extra BusReady-low cycle adds 1.
- ReadData is registered; valid in DONE, held until the next load completes.
- BusReq never drops before BusReady except on timeout or reset.
- Reset mid-BUS: immediate IDLE, BusReq low asynchronously; the transaction is abandoned, and the slave must tolerate this.
- Non-memory instruction in IDLE: Stall=0, zero-cycle overhead.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with off[0]≠0 or word with off≠0 causes no bus access. Stall=0, Fault pulses in that IDLE cycle, ReadData unchanged, store suppressed. Undefined Funct3 also traps.
- Undefined: low address bits are forced to natural alignment (half: off[0]=0; word: off=0) and the access proceeds; Fault only on timeout.

## Structure
- Package lsu_pkg: Funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum, TIMEOUT counter width (10).
- Sub-module lsu_align: combinational store lane shift/BusBe generation and load extract/extend. FSM and registers live in the top.

## Test plan
- sw 0xDEADBEEF @0x100, BusReady on first BUS cycle → BusAddr=0x100, BusBe=1111, BusWData=0xDEADBEEF, Stall high 2 cycles, low in DONE.
- lb @0x203, BusRData=0x80FF_FF00 → BusBe=1000, ReadData=0xFFFFFF80; lbu same → 0x00000080.
- sh 0x1234 @0x42, 3 wait cycles → BusBe=1100, BusWData=0x12341234, Stall high 5 cycles.
- lw with BusReady held 0, TIMEOUT=4 → BusReq drops after 4 BUS cycles, Fault 1-cycle pulse, ReadData=0.
- reset asserted mid-BUS → BusReq=0 and Stall=0 same cycle, state IDLE, next lw completes normally.
- lw @0x101: with LSU_MISALIGN_TRAP_EN → no BusReq, Fault pulse, Stall=0; without → BusAddr=0x100, BusBe=1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: Funct3 encodings, FSM states,
// access-size decoding and the width of the bus timeout counter.
package lsu_pkg;

   // Funct3 encodings for loads and stores
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Width of the BUS-state cycle counter; covers TIMEOUT up to 1023
   localparam int CNT_W = 10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_t;

   // Access size from Funct3; the unused encodings fall back to a word access
   function automatic lsu_size_t f3_size(input logic [2:0] f3);
      case (f3)
         LB, LBU: f3_size = SZ_BYTE;
         LH, LHU: f3_size = SZ_HALF;
         default: f3_size = SZ_WORD;
      endcase
   endfunction

   // Funct3 values that name no load/store width
   function automatic logic f3_undef(input logic [2:0] f3);
      f3_undef = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the load/store unit: store lane shift and byte-enable
// generation with natural-alignment forcing, plus load lane select and
// sign/zero extension. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   output logic [1:0]  o_off,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misalign,
   output logic        o_undef,
   input  logic [2:0]  i_rd_funct3,
   input  logic [1:0]  i_rd_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign o_undef = f3_undef(i_funct3);

   // Store side: replicate data across lanes, pick enables, force low address bits aligned
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      o_off      = i_off;
      o_be       = 4'b0000;
      o_wdata    = i_wdata;
      o_misalign = 1'b0;
      case (f3_size(i_funct3))
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
         end
         SZ_HALF: begin
            o_misalign = i_off[0];
            o_off      = {i_off[1], 1'b0};
            o_be       = i_off[1] ? 4'b1100 : 4'b0011;
            o_wdata    = {2{i_wdata[15:0]}};
         end
         default: begin
            o_misalign = |i_off;
            o_off      = 2'b00;
            o_be       = 4'b1111;
            o_wdata    = i_wdata;
         end
      endcase
   end

   // Load side: select the addressed lane and extend it according to Funct3
   always_comb begin
      case (i_rd_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_rd_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (f3_size(i_rd_funct3))
         SZ_BYTE: o_rdata = i_rd_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_HALF: o_rdata = i_rd_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: o_rdata = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one registered request/ready bus transaction per
// memory instruction (IDLE -> BUS -> DONE), stalls the core while it is in
// flight, and aborts with a Fault pulse after TIMEOUT cycles without BusReady.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned or undefined accesses
// are trapped in IDLE instead of being forced to natural alignment.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Fault,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [31:0] BusWData,
   output logic [3:0]  BusBe,
   input  logic        BusReady,
   input  logic [31:0] BusRData
);

   lsu_state_t       r_state;
   lsu_state_t       w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_funct3;
   logic [1:0]       r_off;
   logic             r_fault;
   logic             r_bus_req;
   logic             r_bus_we;
   logic [31:0]      r_bus_addr;
   logic [31:0]      r_bus_wdata;
   logic [3:0]       r_bus_be;
   logic [31:0]      r_read_data;

   logic             w_req;
   logic             w_trapped;
   logic             w_issue;
   logic             w_capture;
   logic             w_timeout;
   logic             w_trap_fault;
   logic [1:0]       w_off;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_misalign;
   logic             w_undef;
   logic [31:0]      w_rdata_ext;

   assign w_req = MemRead | MemWrite;

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_trapped = w_misalign | w_undef;
`else
   assign w_trapped = 1'b0;
   logic w_unused_trap;
   assign w_unused_trap = &{1'b0, w_misalign, w_undef};
`endif

   lsu_align u_align (
      .i_funct3    (Funct3),
      .i_off       (ALUResult[1:0]),
      .i_wdata     (WriteData),
      .o_off       (w_off),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_misalign  (w_misalign),
      .o_undef     (w_undef),
      .i_rd_funct3 (r_funct3),
      .i_rd_off    (r_off),
      .i_rdata     (BusRData),
      .o_rdata     (w_rdata_ext)
   );

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state is sequential, so it is updated with <= to avoid ordering races between blocks.
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state decode plus the Stall, issue, capture, timeout and trap strobes
   always_comb begin
      w_next_state = r_state;
      Stall        = 1'b0;
      w_issue      = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      w_trap_fault = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req && !reset) begin
               if (w_trapped) begin
                  w_trap_fault = 1'b1;
               end else begin
                  Stall        = 1'b1;
                  w_issue      = 1'b1;
                  w_next_state = S_BUS;
               end
            end
         end
         S_BUS: begin
            Stall = 1'b1;
            if (BusReady) begin
               w_capture    = 1'b1;
               w_next_state = S_DONE;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Bus request registers, wait counter, load result and timeout fault pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
         r_fault     <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'd0;
         r_bus_wdata <= 32'd0;
         r_bus_be    <= 4'd0;
         r_read_data <= 32'd0;
      end else begin
         r_fault <= w_timeout;
         if (w_issue) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= MemWrite;
            r_bus_addr  <= {ALUResult[31:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_bus_be    <= w_be;
            r_funct3    <= Funct3;
            r_off       <= w_off;
            r_cnt       <= '0;
         end else if (r_state == S_BUS && !BusReady) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_capture) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) r_read_data <= w_rdata_ext;
         end
         if (w_timeout) begin
            r_bus_req   <= 1'b0;
            r_read_data <= 32'd0;
         end
      end
   end

   assign ReadData = r_read_data;
   assign Fault    = r_fault | w_trap_fault;
   assign BusReq   = r_bus_req;
   assign BusWe    = r_bus_we;
   assign BusAddr  = r_bus_addr;
   assign BusWData = r_bus_wdata;
   assign BusBe    = r_bus_be;

endmodule
